// File: rtl/fpu_defs_pkg.sv
// fpu_defs: shared FPU definitions.
//   - RISC-V rounding-mode encodings
//   - integer-to-float pipeline depth and payload struct
// The payload is sized for the widest legal operand (64 bits) and exponent
// (16 bits). Narrower configurations use the low exponent bits and the top of
// the left-aligned magnitude.
package fpu_defs;

   localparam logic [2:0] C_RM_RNE = 3'b000;
   localparam logic [2:0] C_RM_RTZ = 3'b001;
   localparam logic [2:0] C_RM_RDN = 3'b010;
   localparam logic [2:0] C_RM_RUP = 3'b011;
   localparam logic [2:0] C_RM_RMM = 3'b100;

   localparam int unsigned C_ITOF_STAGES  = 3;
   localparam int unsigned C_ITOF_MAX_INT = 64;
   localparam int unsigned C_ITOF_MAX_EXP = 16;

   // mag holds the magnitude left-aligned (S1), then the normalised value (S2).
   typedef struct packed {
      logic                    sign;
      logic [2:0]              rm;
      logic [C_ITOF_MAX_INT-1:0] mag;
      logic [C_ITOF_MAX_EXP:0] exp;
      logic                    zero;
   } itof_payload_t;

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero counter.
//   data     : input vector
//   count    : number of leading zeros (0 when data is all zero)
//   all_zero : data == 0
module fpu_lzc #(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] count,
   output logic             all_zero
);

   always_comb begin
      count = '0;
      // Scanning upward lets the highest set bit win.
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (data[i]) count = CNT_W'(int'(WIDTH) - 1 - i);
      end
      all_zero = ~|data;
   end

endmodule

// File: rtl/fpu_itof_pipe.sv
// fpu_itof_pipe: 3-stage integer-to-float converter with valid/ready on both sides.
//   Clk_CI, Rst_RBI      : clock, asynchronous active-low reset
//   Flush_SI             : clears all stage valids at the next edge
//   Valid_SI / Ready_SO  : operand handshake (Operand_DI, Signed_SI, RM_SI)
//   Valid_SO / Ready_SI  : result handshake (Result_DO = {sign, exp, mant}, Inexact_SO)
// S1 takes the absolute value, S2 normalises, S3 rounds and packs.
module fpu_itof_pipe
   import fpu_defs::*;
#(
   parameter int unsigned C_INT_WIDTH = 32,
   parameter int unsigned C_EXP       = 8,
   parameter int unsigned C_MANT      = 23,
   parameter int unsigned C_BIAS      = 127
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RBI,
   input  logic                      Flush_SI,
   input  logic                      Valid_SI,
   output logic                      Ready_SO,
   input  logic [C_INT_WIDTH-1:0]    Operand_DI,
   input  logic                      Signed_SI,
   input  logic [2:0]                RM_SI,
   output logic                      Valid_SO,
   input  logic                      Ready_SI,
   output logic [C_EXP+C_MANT:0]     Result_DO,
   output logic                      Inexact_SO
);

   localparam int unsigned C_MW   = C_ITOF_MAX_INT;
   localparam int unsigned C_LZW  = $clog2(C_MW);
   localparam int unsigned C_RESW = 1 + C_EXP + C_MANT;

   if (C_INT_WIDTH < 8 || C_INT_WIDTH > 64) begin : g_bad_width
      $error("fpu_itof_pipe: C_INT_WIDTH must be in 8..64");
   end
   if (C_EXP > C_ITOF_MAX_EXP || C_MANT > C_MW - 3 || C_MANT < 1) begin : g_bad_format
      $error("fpu_itof_pipe: unsupported C_EXP/C_MANT");
   end
   if (!(C_BIAS + C_INT_WIDTH < 2 ** C_EXP - 1)) begin : g_bad_bias
      $error("fpu_itof_pipe: exponent could overflow");
   end

   logic v1_q, v2_q, v3_q;
   logic acc1, acc2, acc3;
   itof_payload_t s1_d, s1_q, s2_d, s2_q;
   logic [C_RESW-1:0] res_d, res_q;
   logic nx_d, nx_q;

   // Stall chain: a stage accepts when empty or when its successor accepts.
   assign acc3     = ~v3_q | Ready_SI;
   assign acc2     = ~v2_q | acc3;
   assign acc1     = ~v1_q | acc2;
   assign Ready_SO = acc1;

   // S1: absolute value, magnitude left-aligned in the payload.
   logic                   op_neg;
   logic [C_INT_WIDTH-1:0] op_abs;

   always_comb begin
      op_neg   = Signed_SI & Operand_DI[C_INT_WIDTH-1];
      op_abs   = op_neg ? (~Operand_DI + C_INT_WIDTH'(1)) : Operand_DI;
      s1_d      = '0;
      s1_d.sign = op_neg;
      s1_d.rm   = RM_SI;
      s1_d.mag  = C_MW'(op_abs) << (C_MW - C_INT_WIDTH);
   end

   // S2: normalise so the hidden bit lands in the MSB.
   logic [C_LZW-1:0] lz;
   logic             lz_zero;

   fpu_lzc #(
      .WIDTH (C_MW)
   ) u_lzc (
      .data     (s1_q.mag),
      .count    (lz),
      .all_zero (lz_zero)
   );

   always_comb begin
      s2_d      = s1_q;
      s2_d.mag  = s1_q.mag << lz;
      s2_d.zero = lz_zero;
      s2_d.exp  = '0;
      s2_d.exp[C_EXP:0] = (C_EXP + 1)'(C_BIAS + C_INT_WIDTH - 1) - (C_EXP + 1)'(lz);
   end

   // S3: round and pack.
   logic [C_MANT-1:0] mant;
   logic              guard, sticky, inexact, round_up;
   logic [C_MANT:0]   mant_rnd;
   logic [C_EXP-1:0]  exp_rnd;

   always_comb begin
      mant    = s2_q.mag[C_MW-2 -: C_MANT];
      guard   = s2_q.mag[C_MW-2-C_MANT];
      sticky  = |s2_q.mag[C_MW-3-C_MANT:0];
      inexact = guard | sticky;
      case (s2_q.rm)
         C_RM_RTZ: round_up = 1'b0;
         C_RM_RDN: round_up = s2_q.sign & inexact;
         C_RM_RUP: round_up = ~s2_q.sign & inexact;
         C_RM_RMM: round_up = guard;
         default:  round_up = guard & (sticky | mant[0]);
      endcase
      // A carry out leaves the low mantissa bits zero and bumps the exponent.
      mant_rnd = {1'b0, mant} + (C_MANT + 1)'(round_up);
      exp_rnd  = s2_q.exp[C_EXP-1:0] + C_EXP'(mant_rnd[C_MANT]);
      res_d    = {s2_q.sign, exp_rnd, mant_rnd[C_MANT-1:0]};
      nx_d     = inexact;
      if (s2_q.zero) begin
         res_d = '0;
         nx_d  = 1'b0;
      end
   end

   // Hidden bit and exponent headroom are not needed after normalisation.
   logic unused_bits;
   assign unused_bits = ^{s2_q.mag[C_MW-1], s2_q.exp[C_ITOF_MAX_EXP:C_EXP]};

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (Flush_SI) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         if (acc1) v1_q <= Valid_SI;
         if (acc2) v2_q <= v1_q;
         if (acc3) v3_q <= v2_q;
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         s1_q  <= '0;
         s2_q  <= '0;
         res_q <= '0;
         nx_q  <= 1'b0;
      end else begin
         if (Valid_SI & acc1) s1_q <= s1_d;
         if (v1_q & acc2)     s2_q <= s2_d;
         if (v2_q & acc3) begin
            res_q <= res_d;
            nx_q  <= nx_d;
         end
      end
   end

   assign Valid_SO   = v3_q;
   assign Result_DO  = res_q;
   assign Inexact_SO = nx_q;

endmodule

// File: tb/tb_fpu_itof_pipe.sv
// Scoreboard bench for fpu_itof_pipe (default 32-bit int -> binary32).
module tb_fpu_itof_pipe;

   logic        Clk_CI;
   logic        Rst_RBI;
   logic        Flush_SI;
   logic        Valid_SI;
   logic        Ready_SO;
   logic [31:0] Operand_DI;
   logic        Signed_SI;
   logic [2:0]  RM_SI;
   logic        Valid_SO;
   logic        Ready_SI;
   logic [31:0] Result_DO;
   logic        Inexact_SO;

   fpu_itof_pipe u_dut (
      .Clk_CI     (Clk_CI),
      .Rst_RBI    (Rst_RBI),
      .Flush_SI   (Flush_SI),
      .Valid_SI   (Valid_SI),
      .Ready_SO   (Ready_SO),
      .Operand_DI (Operand_DI),
      .Signed_SI  (Signed_SI),
      .RM_SI      (RM_SI),
      .Valid_SO   (Valid_SO),
      .Ready_SI   (Ready_SI),
      .Result_DO  (Result_DO),
      .Inexact_SO (Inexact_SO)
   );

   initial Clk_CI = 1'b0;
   always #5 Clk_CI = ~Clk_CI;

   typedef struct {
      logic [31:0] res;
      logic        nx;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cycle    = 0;
   bit          lat_check = 1'b0;
   bit          rnd_done  = 1'b0;
   bit          hold_armed = 1'b0;
   logic [31:0] hold_res;
   logic        hold_nx;

   always @(posedge Clk_CI) cycle <= cycle + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cycle);
      end
   endtask

   // Reference: exact magnitude, integer log2, remainder compared with half an ulp.
   task automatic model(input logic [31:0] op, input logic sg, input logic [2:0] rm,
                        output logic [31:0] res, output logic nx);
      logic        s, up;
      logic [63:0] mag, q, rem, unit, rem2;
      int          e, d;
      s   = sg & op[31];
      mag = s ? (64'h1_0000_0000 - {32'h0, op}) : {32'h0, op};
      res = '0;
      nx  = 1'b0;
      if (mag == 0) return;
      e = 63;
      while ((mag >> e) == 0) e--;
      if (e > 23) begin
         d    = e - 23;
         q    = mag >> d;
         rem  = mag - (q << d);
         unit = 64'd1 << d;
      end else begin
         q    = mag << (23 - e);
         rem  = 0;
         unit = 1;
      end
      rem2 = rem << 1;
      nx   = (rem != 0);
      case (rm)
         3'd1:    up = 1'b0;
         3'd2:    up = s & nx;
         3'd3:    up = !s & nx;
         3'd4:    up = nx && (rem2 >= unit);
         default: up = (rem2 > unit) || ((rem2 == unit) && q[0]);
      endcase
      q = q + {63'd0, up};
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      res = {s, 8'(e + 127), q[22:0]};
   endtask

   task automatic send(input logic [31:0] op, input logic sg, input logic [2:0] rm,
                       input logic [31:0] want_res, input logic want_nx);
      exp_t item;
      Operand_DI = op;
      Signed_SI  = sg;
      RM_SI      = rm;
      Valid_SI   = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge Clk_CI);
         if (Ready_SO && !Flush_SI) begin
            item = '{want_res, want_nx, cycle + 1, lat_check};
            sb.push_back(item);
            @(posedge Clk_CI);
            #1;
            Valid_SI = 1'b0;
            return;
         end
         @(posedge Clk_CI);
         #1;
      end
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got Ready_SO=0 for 200 cycles expected 1");
      Valid_SI = 1'b0;
   endtask

   task automatic send_model(input logic [31:0] op, input logic sg, input logic [2:0] rm);
      logic [31:0] r;
      logic        x;
      model(op, sg, rm, r, x);
      send(op, sg, rm, r, x);
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         if (sb.size() == 0) return;
         @(posedge Clk_CI);
         #1;
      end
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
   endtask

   // Monitor: pops and compares on every output handshake, checks hold under stall.
   always @(negedge Clk_CI) begin
      exp_t e;
      if (Rst_RBI) begin
         if (hold_armed) begin
            check("hold_valid", {63'd0, Valid_SO}, 64'd1);
            check("hold_result", {31'd0, Result_DO, Inexact_SO}, {31'd0, hold_res, hold_nx});
         end
         if (Valid_SO && Ready_SI) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %h expected none", Result_DO);
            end else begin
               e = sb.pop_front();
               check("result", {32'd0, Result_DO}, {32'd0, e.res});
               check("inexact", {63'd0, Inexact_SO}, {63'd0, e.nx});
               if (e.lat) check("latency", 64'(cycle + 1 - e.acc), 64'd3);
            end
         end
         hold_armed = Valid_SO && !Ready_SI && !Flush_SI;
         hold_res   = Result_DO;
         hold_nx    = Inexact_SO;
      end else begin
         hold_armed = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_RBI    = 1'b0;
      Flush_SI   = 1'b0;
      Valid_SI   = 1'b0;
      Operand_DI = '0;
      Signed_SI  = 1'b0;
      RM_SI      = 3'd0;
      Ready_SI   = 1'b1;

      // Reset state
      repeat (2) @(negedge Clk_CI);
      check("rst_valid", {63'd0, Valid_SO}, 64'd0);
      check("rst_result", {32'd0, Result_DO}, 64'd0);
      check("rst_inexact", {63'd0, Inexact_SO}, 64'd0);
      @(posedge Clk_CI);
      #1;
      Rst_RBI = 1'b1;
      @(negedge Clk_CI);
      check("rst_ready", {63'd0, Ready_SO}, 64'd1);
      @(posedge Clk_CI);
      #1;

      // Directed conversions, downstream always ready
      lat_check = 1'b1;
      send(32'h0000_0001, 1'b1, 3'd0, 32'h3F80_0000, 1'b0);
      drain();
      send(32'hFFFF_FFFF, 1'b1, 3'd0, 32'hBF80_0000, 1'b0);
      send(32'h8000_0000, 1'b1, 3'd0, 32'hCF00_0000, 1'b0);
      send(32'h0000_0000, 1'b1, 3'd2, 32'h0000_0000, 1'b0);
      send(32'hFFFF_FFFF, 1'b0, 3'd0, 32'h4F80_0000, 1'b1);
      send(32'hFFFF_FFFF, 1'b0, 3'd1, 32'h4F7F_FFFF, 1'b1);
      send(32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1);
      send(32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1);
      send(32'hFEFF_FFFF, 1'b1, 3'd2, 32'hCB80_0001, 1'b1);
      drain();

      // Backpressure: 6 operands, downstream stalled for 5 cycles
      lat_check = 1'b0;
      Ready_SI  = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send_model(32'h0000_1000 * (i + 3) + 32'(i), 1'b1, 3'(i));
         end
         begin
            repeat (3) @(negedge Clk_CI);
            @(negedge Clk_CI);
            check("bp_ready_full", {63'd0, Ready_SO}, 64'd0);
            @(negedge Clk_CI);
            check("bp_ready_full2", {63'd0, Ready_SO}, 64'd0);
            @(posedge Clk_CI);
            #1;
            Ready_SI = 1'b1;
            for (int i = 0; i < 6; i++) begin
               @(negedge Clk_CI);
               check("bp_stream_valid", {63'd0, Valid_SO}, 64'd1);
            end
         end
      join
      drain();

      // Flush with all stages full; the operand presented during flush is dropped
      Ready_SI = 1'b0;
      for (int i = 0; i < 3; i++) send_model(32'h0001_0000 + 32'(i), 1'b0, 3'd0);
      Flush_SI   = 1'b1;
      Valid_SI   = 1'b1;
      Operand_DI = 32'h0000_0777;
      sb.delete();
      @(posedge Clk_CI);
      #1;
      Flush_SI = 1'b0;
      Valid_SI = 1'b0;
      @(negedge Clk_CI);
      check("flush_valid", {63'd0, Valid_SO}, 64'd0);
      check("flush_ready", {63'd0, Ready_SO}, 64'd1);
      @(posedge Clk_CI);
      #1;
      Ready_SI = 1'b1;
      send_model(32'hFFFF_FF85, 1'b1, 3'd0);
      drain();

      // Asynchronous reset mid-stream
      Ready_SI = 1'b0;
      for (int i = 0; i < 3; i++) send_model(32'h1234_5678 + 32'(i), 1'b0, 3'd0);
      #2;
      Rst_RBI = 1'b0;
      #1;
      check("arst_valid", {63'd0, Valid_SO}, 64'd0);
      check("arst_result", {32'd0, Result_DO}, 64'd0);
      check("arst_inexact", {63'd0, Inexact_SO}, 64'd0);
      sb.delete();
      @(posedge Clk_CI);
      #1;
      Rst_RBI  = 1'b1;
      Ready_SI = 1'b1;
      @(negedge Clk_CI);
      check("arst_ready", {63'd0, Ready_SO}, 64'd1);
      @(posedge Clk_CI);
      #1;
      send_model(32'h00AB_CDEF, 1'b0, 3'd4);
      drain();

      // Randomised stream with random backpressure and idle gaps
      fork
         begin
            logic [31:0] op;
            for (int i = 0; i < 300; i++) begin
               op = $urandom >> $urandom_range(0, 31);
               case ($urandom_range(0, 15))
                  0: op = 32'h8000_0000;
                  1: op = 32'hFFFF_FFFF;
                  2: op = 32'h0000_0000;
                  3: op = 32'h0100_0001 + ($urandom_range(0, 3) << 24);
                  default: ;
               endcase
               send_model(op, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 2)) @(posedge Clk_CI);
                  #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge Clk_CI);
               #1;
               Ready_SI = ($urandom_range(0, 3) != 0);
            end
         end
      join
      Ready_SI = 1'b1;
      drain();
      repeat (3) @(posedge Clk_CI);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_itof_pipe.md
Name: fpu_itof_pipe

Overview:
Parametrised, fully normalising and rounding integer-to-float converter with a valid/ready handshake on both sides.
Successor to the combinational itof prenormaliser. It handles signed and unsigned sources, any integer width from 8 to 64, and RISC-V rounding modes, and outputs a packed IEEE-754 result plus an inexact flag.
It sits in the FPU datapath as its own 3-stage pipelined functional unit, and no external normaliser or rounder follows it.

Parameters:
C_INT_WIDTH, 32, integer operand width (8..64)
C_EXP, 8, result exponent width
C_MANT, 23, result stored mantissa width, hidden bit excluded
C_BIAS, 127, exponent bias

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
Flush_SI  in  1  synchronous flush; clears all stage valids
Valid_SI  in  1  input operand valid
Ready_SO  out  1  converter can accept an operand this cycle
Operand_DI  in  C_INT_WIDTH  integer operand
Signed_SI  in  1  1: two's complement operand, 0: unsigned operand
RM_SI  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes act as RNE
Valid_SO  out  1  result valid
Ready_SI  in  1  downstream accepts the result
Result_DO  out  1+C_EXP+C_MANT  packed float {sign, exp, mant}
Inexact_SO  out  1  result was rounded (NX)

Behaviour:
- Reset (async, Rst_RBI=0): all stage valids = 0, Valid_SO=0, Result_DO=0, Inexact_SO=0. Ready_SO=1 once reset is released.
- Stage 1 (S1), absolute value:
  - sign = Signed_SI & Operand_DI[MSB].
  - mag = sign ? (~Operand_DI + 1) : Operand_DI, as a C_INT_WIDTH-bit unsigned value.
  - INT_MIN gives mag = 2^(W-1), which is correct.
  - RM_SI is captured alongside.
- Stage 2 (S2), normalise:
  - lz = leading-zero count of mag; zero flag when mag == 0.
  - norm = mag << lz, so the MSB is the hidden bit.
  - exp = C_BIAS + C_INT_WIDTH - 1 - lz, computed with C_EXP+1 bits.
- Stage 3 (S3), round and pack:
  - mant = norm[W-2 -: C_MANT], zero-padded when W-1 < C_MANT.
  - guard = next bit below mant; sticky = OR of all remaining lower bits.
  - inexact = guard | sticky.
  - Round-up rule:
    - RNE: guard & (sticky | mant LSB)
    - RTZ: 0
    - RDN: sign & inexact
    - RUP: ~sign & inexact
    - RMM: guard
  - Mantissa carry-out sets mant = 0 and exp += 1.
  - mag == 0 gives Result = {0, 0, 0} (+0.0 in all modes) and Inexact = 0.
  - Exponent overflow cannot occur for legal parameters; an elaboration assertion requires C_BIAS + C_INT_WIDTH < 2^C_EXP - 1.
- Handshake:
  - Each stage holds a valid bit, and data registers load only on advance.
  - adv3 = Valid_SO & Ready_SI.
  - Stage k accepts when its valid = 0 or stage k+1 accepts (standard stall chain).
  - Ready_SO = ~v1 | stage-2 accepts.
  - Transfer on either port only when valid & ready are both high.
- Latency and throughput: latency 3 cycles from input handshake to Valid_SO with Ready_SI=1. Throughput 1 per cycle.
- Backpressure: Ready_SI=0 holds Result_DO, Inexact_SO and Valid_SO stable. Once all 3 stages are full, Ready_SO=0.
- Ordering: results leave in input order. No bubbles are inserted while downstream is ready.
- Flush:
  - Flush_SI=1 clears v1..v3 at the next edge, and an input presented that same cycle is dropped.
  - Ready_SO=1 in the cycle after the flush.
  - Data registers need not clear; Valid_SO=0 masks them.
- Simultaneous events: accept and drain in the same cycle while full is allowed, with no lost or duplicated items.
- Reset mid-operation: everything is discarded immediately and asynchronously.

Decomposition:
- fpu_defs package gains:
  - rounding-mode constants C_RM_RNE, C_RM_RTZ, C_RM_RDN, C_RM_RUP, C_RM_RMM;
  - C_ITOF_STAGES = 3;
  - a pipeline payload typedef struct {sign, rm, mag/norm, exp, zero}.
- One sub-module: fpu_lzc. It is a parametrised leading-zero counter (WIDTH, count output of clog2(WIDTH) bits, all-zero flag), is combinational, and is reusable by the other units.

Test Plan:
1. Signed 32'h00000001, RNE, Ready_SI=1 -> Result 32'h3F800000, Inexact 0, Valid_SO exactly 3 cycles after the input handshake.
2. Signed 32'hFFFFFFFF -> 32'hBF800000; signed 32'h80000000 -> 32'hCF000000, Inexact 0; operand 0 in RDN -> 32'h00000000.
3. Unsigned 32'hFFFFFFFF:
   - RNE -> 32'h4F800000, Inexact 1 (carry into exponent);
   - RTZ -> 32'h4F7FFFFF, Inexact 1.
4. Unsigned 32'h01000001:
   - RNE -> 32'h4B800000 (tie to even);
   - RUP -> 32'h4B800001;
   - signed negated (32'hFEFFFFFF) with RDN -> 32'hCB800001.
   All three have Inexact 1.
5. Stream 6 back-to-back operands with Ready_SI=0 for 5 cycles:
   - Ready_SO drops after 3 accepts;
   - Valid_SO and Result_DO are held stable;
   - on release, all 6 results emerge in order, one per cycle, with no loss or duplication.
6. Reset and flush with 3 stages full:
   - Flush_SI=1 -> next cycle Valid_SO=0, Ready_SO=1, and a new operand converts correctly;
   - Rst_RBI pulsed low mid-stream -> outputs go to 0 immediately, asynchronously.
